// File: rtl/enigma_pkg.sv
// Shared letter constants, default rotor notches, controller state encoding
// and mod-26 position helpers for the Enigma keypress sequencer.
package enigma_pkg;

    localparam int NUM_LETTERS = 26;

    localparam logic [4:0] A = 5'd0;
    localparam logic [4:0] B = 5'd1;
    localparam logic [4:0] C = 5'd2;
    localparam logic [4:0] D = 5'd3;
    localparam logic [4:0] E = 5'd4;
    localparam logic [4:0] F = 5'd5;
    localparam logic [4:0] G = 5'd6;
    localparam logic [4:0] H = 5'd7;
    localparam logic [4:0] I = 5'd8;
    localparam logic [4:0] J = 5'd9;
    localparam logic [4:0] K = 5'd10;
    localparam logic [4:0] L = 5'd11;
    localparam logic [4:0] M = 5'd12;
    localparam logic [4:0] N = 5'd13;
    localparam logic [4:0] O = 5'd14;
    localparam logic [4:0] P = 5'd15;
    localparam logic [4:0] Q = 5'd16;
    localparam logic [4:0] R = 5'd17;
    localparam logic [4:0] S = 5'd18;
    localparam logic [4:0] T = 5'd19;
    localparam logic [4:0] U = 5'd20;
    localparam logic [4:0] V = 5'd21;
    localparam logic [4:0] W = 5'd22;
    localparam logic [4:0] X = 5'd23;
    localparam logic [4:0] Y = 5'd24;
    localparam logic [4:0] Z = 5'd25;

    localparam logic [4:0] NOTCH_I   = Q;
    localparam logic [4:0] NOTCH_II  = E;
    localparam logic [4:0] NOTCH_III = V;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // Positions are always 0..25, so Z is the only value that wraps.
    function automatic logic [4:0] inc_pos(input logic [4:0] p);
        return (p >= 5'(NUM_LETTERS - 1)) ? 5'd0 : p + 5'd1;
    endfunction

    // Reduce a raw 5-bit load field (0..31) into 0..25.
    function automatic logic [4:0] fold_pos(input logic [4:0] p);
        return (p >= 5'(NUM_LETTERS)) ? p - 5'(NUM_LETTERS) : p;
    endfunction

endpackage

// File: rtl/rotor_stepper.sv
// Combinational odometer stepping for three rotors, including the middle
// rotor double-step when it sits on its own notch.
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter logic [4:0] NOTCH_M = NOTCH_II,
    parameter logic [4:0] NOTCH_R = NOTCH_III
) (
    input  logic [4:0] pos_l,
    input  logic [4:0] pos_m,
    input  logic [4:0] pos_r,
    output logic [4:0] next_l,
    output logic [4:0] next_m,
    output logic [4:0] next_r,
    output logic       adv_l,
    output logic       adv_m,
    output logic       adv_r
);

    // Index 0 = right, 1 = middle, 2 = left.
    logic [4:0] pos_a [3];
    logic [4:0] next_a [3];
    logic       adv_a [3];

    assign pos_a[0] = pos_r;
    assign pos_a[1] = pos_m;
    assign pos_a[2] = pos_l;

    assign adv_a[0] = 1'b1;
    assign adv_a[1] = (pos_r == NOTCH_R) || (pos_m == NOTCH_M);
    assign adv_a[2] = (pos_m == NOTCH_M);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rotor
            assign next_a[gi] = adv_a[gi] ? inc_pos(pos_a[gi]) : pos_a[gi];
        end
    endgenerate

    assign next_r = next_a[0];
    assign next_m = next_a[1];
    assign next_l = next_a[2];
    assign adv_r  = adv_a[0];
    assign adv_m  = adv_a[1];
    assign adv_l  = adv_a[2];

endmodule

// File: rtl/enigma_step_controller.sv
// Keypress sequencer: steps the rotors, drives the letter into the rotor chain,
// waits for it to settle and captures the ciphertext letter.
module enigma_step_controller
    import enigma_pkg::*;
#(
    parameter logic [4:0] NOTCH_L       = NOTCH_I,
    parameter logic [4:0] NOTCH_M       = NOTCH_II,
    parameter logic [4:0] NOTCH_R       = NOTCH_III,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        load_en,
    input  logic [14:0] load_pos,
    input  logic        key_valid,
    input  logic [4:0]  key_letter,
    output logic        key_ready,
    output logic [4:0]  pos_l,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_r,
    output logic        step_l,
    output logic        step_m,
    output logic        step_r,
    output logic [4:0]  rotor_in,
    input  logic [4:0]  datapath_out,
    output logic        out_valid,
    output logic [4:0]  out_letter,
    output logic        busy,
    output logic        bad_key
);

    // An out-of-range notch or settle time would corrupt stepping or timing,
    // so such a build never accepts a key.
    localparam logic PARAMS_OK = (NOTCH_L <= Z) && (NOTCH_M <= Z) && (NOTCH_R <= Z)
                              && (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 15);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [3:0] counter_reg;
    logic [4:0] pos_reg [3];
    logic [4:0] load_a [3];
    logic [4:0] next_l, next_m, next_r;
    logic       adv_l, adv_m, adv_r;
    logic       key_accept, key_in_range, settle_done;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_load
            assign load_a[gi] = fold_pos(load_pos[gi*5 +: 5]);
        end
    endgenerate

    rotor_stepper #(
        .NOTCH_M (NOTCH_M),
        .NOTCH_R (NOTCH_R)
    ) u_stepper (
        .pos_l  (pos_reg[2]),
        .pos_m  (pos_reg[1]),
        .pos_r  (pos_reg[0]),
        .next_l (next_l),
        .next_m (next_m),
        .next_r (next_r),
        .adv_l  (adv_l),
        .adv_m  (adv_m),
        .adv_r  (adv_r)
    );

    assign key_accept   = key_valid && key_ready;
    assign key_in_range = (key_letter <= Z);
    assign settle_done  = (counter_reg == SETTLE_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (key_accept && key_in_range) state_next = STEP;
            STEP:    state_next = SETTLE;
            SETTLE:  if (settle_done) state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        key_ready = PARAMS_OK && (state_reg == IDLE) && !load_en;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) pos_reg[i] <= 5'd0;
            counter_reg <= 4'd0;
            rotor_in    <= 5'd0;
            out_letter  <= 5'd0;
            out_valid   <= 1'b0;
            bad_key     <= 1'b0;
            step_l      <= 1'b0;
            step_m      <= 1'b0;
            step_r      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            bad_key   <= 1'b0;
            step_l    <= 1'b0;
            step_m    <= 1'b0;
            step_r    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_en) begin
                        for (int i = 0; i < 3; i++) pos_reg[i] <= load_a[i];
                    end else if (key_accept) begin
                        if (key_in_range) rotor_in <= key_letter;
                        else              bad_key  <= 1'b1;
                    end
                end
                STEP: begin
                    pos_reg[0]  <= next_r;
                    pos_reg[1]  <= next_m;
                    pos_reg[2]  <= next_l;
                    step_r      <= adv_r;
                    step_m      <= adv_m;
                    step_l      <= adv_l;
                    counter_reg <= 4'd0;
                end
                SETTLE: counter_reg <= counter_reg + 4'd1;
                CAPTURE: begin
                    out_letter <= datapath_out;
                    out_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pos_r = pos_reg[0];
    assign pos_m = pos_reg[1];
    assign pos_l = pos_reg[2];

endmodule

// File: tb/tb_enigma_step_controller.sv
// Directed bench for enigma_step_controller: loads, stepping, double step,
// wrap-around, bad keys, held keys while busy and mid-operation reset.
module tb_enigma_step_controller;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        load_en = 1'b0;
    logic [14:0] load_pos = 15'd0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_letter = 5'd0;
    logic        key_ready;
    logic [4:0]  pos_l, pos_m, pos_r;
    logic        step_l, step_m, step_r;
    logic [4:0]  rotor_in;
    logic [4:0]  datapath_out;
    logic        out_valid;
    logic [4:0]  out_letter;
    logic        busy;
    logic        bad_key;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Stand-in rotor chain: ciphertext = (letter + right position) mod 26.
    assign datapath_out = 5'((int'(rotor_in) + int'(pos_r)) % 26);

    enigma_step_controller #(
        .NOTCH_L       (5'd16),
        .NOTCH_M       (5'd4),
        .NOTCH_R       (5'd21),
        .SETTLE_CYCLES (2)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .load_en      (load_en),
        .load_pos     (load_pos),
        .key_valid    (key_valid),
        .key_letter   (key_letter),
        .key_ready    (key_ready),
        .pos_l        (pos_l),
        .pos_m        (pos_m),
        .pos_r        (pos_r),
        .step_l       (step_l),
        .step_m       (step_m),
        .step_r       (step_r),
        .rotor_in     (rotor_in),
        .datapath_out (datapath_out),
        .out_valid    (out_valid),
        .out_letter   (out_letter),
        .busy         (busy),
        .bad_key      (bad_key)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pk(input int l, input int m, input int r);
        return l * 1024 + m * 32 + r;
    endfunction

    function automatic int cur_pos();
        return pk(int'(pos_l), int'(pos_m), int'(pos_r));
    endfunction

    function automatic int cur_steps();
        return {29'd0, step_l, step_m, step_r};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input int l, input int m, input int r, input int el, input int em, input int er);
        load_en  = 1'b1;
        load_pos = {5'(l), 5'(m), 5'(r)};
        tick();
        load_en = 1'b0;
        check_eq("load_pos", cur_pos(), pk(el, em, er));
        $display("load  {%0d,%0d,%0d} -> pos %0d,%0d,%0d", l, m, r, pos_l, pos_m, pos_r);
    endtask

    task automatic do_key(input string tag, input int letter, input int el, input int em, input int er,
                          input int esteps, input int eout);
        int n;
        key_valid  = 1'b1;
        key_letter = 5'(letter);
        tick();
        key_valid = 1'b0;
        check_eq({tag, "_busy"}, int'(busy), 1);
        tick();
        check_eq({tag, "_steps"}, cur_steps(), esteps);
        check_eq({tag, "_pos"}, cur_pos(), pk(el, em, er));
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, n, 4);
        check_eq({tag, "_out"}, int'(out_letter), eout);
        tick();
        check_eq({tag, "_pulse"}, int'(out_valid), 0);
        $display("key %s letter %0d -> pos %0d,%0d,%0d out %0d", tag, letter, pos_l, pos_m, pos_r, out_letter);
    endtask

    initial begin
        int n;
        int seen_valid;

        // Reset state
        tick();
        check_eq("rst_pos", cur_pos(), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        resetn = 1'b1;
        tick();
        check_eq("rst_key_ready", int'(key_ready), 1);
        check_eq("rst_out_letter", int'(out_letter), 0);
        $display("reset released");

        // Single key from AAA
        do_load(0, 0, 0, 0, 0, 0);
        do_key("aaa", 0, 0, 0, 1, 3'b001, 1);

        // Notch carry and double step
        do_load(0, 3, 20, 0, 3, 20);
        do_key("ds1", 1, 0, 3, 21, 3'b001, 22);
        do_key("ds2", 2, 0, 4, 22, 3'b011, 24);
        do_key("ds3", 3, 1, 5, 23, 3'b111, 0);

        // Wrap-around
        do_load(25, 25, 25, 25, 25, 25);
        do_key("zzz", 0, 25, 25, 0, 3'b001, 0);
        do_load(25, 4, 21, 25, 4, 21);
        do_key("lwrap", 5, 0, 5, 22, 3'b111, 1);

        // Out-of-range key
        key_valid  = 1'b1;
        key_letter = 5'd27;
        tick();
        key_valid = 1'b0;
        check_eq("bad_pulse", int'(bad_key), 1);
        check_eq("bad_busy", int'(busy), 0);
        check_eq("bad_ready", int'(key_ready), 1);
        check_eq("bad_steps", cur_steps(), 0);
        tick();
        check_eq("bad_pulse_end", int'(bad_key), 0);
        check_eq("bad_no_out", int'(out_valid), 0);
        check_eq("bad_pos", cur_pos(), pk(0, 5, 22));
        $display("bad key 27 consumed, pos %0d,%0d,%0d", pos_l, pos_m, pos_r);

        // Held key while busy, load ignored mid-SETTLE
        key_valid  = 1'b1;
        key_letter = 5'd2;
        tick();
        tick();
        check_eq("hold_pos1", cur_pos(), pk(0, 5, 23));
        load_en  = 1'b1;
        load_pos = 15'd0;
        check_eq("hold_ready", int'(key_ready), 0);
        tick();
        check_eq("busy_load_ignored", cur_pos(), pk(0, 5, 23));
        load_en = 1'b0;
        tick();
        check_eq("hold_no_early_out", int'(out_valid), 0);
        check_eq("hold_ready_capture", int'(key_ready), 0);
        tick();
        check_eq("hold_out_valid", int'(out_valid), 1);
        check_eq("hold_out", int'(out_letter), 25);
        check_eq("hold_idle", int'(busy), 0);
        tick();
        check_eq("hold_reaccept", int'(busy), 1);
        key_valid = 1'b0;
        tick();
        check_eq("hold_pos2", cur_pos(), pk(0, 5, 24));
        check_eq("hold_steps2", cur_steps(), 3'b001);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("hold_out2", int'(out_letter), 0);
        tick();
        $display("held key C: two accepts, pos %0d,%0d,%0d", pos_l, pos_m, pos_r);

        // Reset during SETTLE
        key_valid  = 1'b1;
        key_letter = 5'd7;
        tick();
        key_valid = 1'b0;
        tick();
        check_eq("abort_pre_pos", cur_pos(), pk(0, 5, 25));
        resetn = 1'b0;
        #1;
        check_eq("abort_pos", cur_pos(), 0);
        check_eq("abort_rotor_in", int'(rotor_in), 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_steps", cur_steps(), 0);
        seen_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) seen_valid = 1;
        end
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) seen_valid = 1;
        end
        check_eq("abort_no_out", seen_valid, 0);
        check_eq("abort_ready", int'(key_ready), 1);
        $display("reset during SETTLE aborted sequence");

        // Load field folding
        do_load(30, 31, 26, 4, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
